// File: rtl/rvfi_retire_buffer.sv
// rvfi_retire_buffer: records issued instructions in order, matches them against commits,
// and drains the retired records to the tracer one per cycle.
module rvfi_retire_buffer #(
  parameter int IssueW = 2,
  parameter int CmtW   = 2,
  parameter int Depth  = 16,
  parameter int ScanW  = 4,
  parameter int PlW    = 5,
  parameter int IssW   = 96,
  parameter int CmtDW  = 96
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [IssueW-1:0]         iss_valid_i,
  input  logic [IssueW-1:0]         iss_is_ex_i,
  input  logic [IssueW*PlW-1:0]     iss_pl_i,
  input  logic [IssueW*IssW-1:0]    iss_data_i,
  output logic                      iss_rdy_o,
  input  logic [CmtW-1:0]           cmt_valid_i,
  input  logic [CmtW*PlW-1:0]       cmt_pl_i,
  input  logic [CmtW*CmtDW-1:0]     cmt_data_i,
  input  logic                      flush_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [IssW-1:0]           out_iss_data_o,
  output logic [CmtDW-1:0]          out_cmt_data_o,
  output logic                      out_is_ex_o,
  output logic                      mismatch_o,
  output logic                      overflow_o,
  output logic [$clog2(Depth):0]    occupancy_o
);
  localparam int AW = $clog2(Depth);
  localparam int PW = AW + 1;
  typedef logic [PW-1:0] ptr_t;
  ptr_t wr_q, wr_d, cmt_q, cmt_d, rd_q, rd_d, widx, ridx, avail;
  logic [IssW-1:0]  iss_mem_q [Depth];
  logic [IssW-1:0]  iss_mem_d [Depth];
  logic [CmtDW-1:0] cmt_mem_q [Depth];
  logic [CmtDW-1:0] cmt_mem_d [Depth];
  logic [PlW-1:0]   pl_mem_q  [Depth];
  logic [PlW-1:0]   pl_mem_d  [Depth];
  logic [Depth-1:0] ex_q, ex_d;
  logic iss_rdy_q, iss_rdy_d, mismatch_q, mismatch_d, overflow_q, overflow_d;
  logic go, tag_bad;
  int n_iss, n_cmt, n_ret, k;
  always_comb begin
    iss_mem_d = iss_mem_q;
    cmt_mem_d = cmt_mem_q;
    pl_mem_d  = pl_mem_q;
    ex_d      = ex_q;
    widx      = '0;
    ridx      = '0;
    n_iss     = 0;
    n_cmt     = 0;
    n_ret     = 0;
    k         = 0;
    go        = 1'b1;
    tag_bad   = 1'b0;
    for (int i = 0; i < IssueW; i++)
      if (iss_valid_i[i]) begin
        widx = wr_q + ptr_t'(n_iss);
        if (iss_rdy_q) begin
          iss_mem_d[widx[AW-1:0]] = iss_data_i[i*IssW +: IssW];
          pl_mem_d[widx[AW-1:0]]  = iss_pl_i[i*PlW +: PlW];
          ex_d[widx[AW-1:0]]      = iss_is_ex_i[i];
        end
        n_iss = n_iss + 1;
      end
    for (int j = 0; j < CmtW; j++) n_cmt = n_cmt + int'(cmt_valid_i[j]);
    // Only entries present at the start of the cycle are scanned; new issues land at or beyond wr_q.
    avail = wr_q - cmt_q;
    for (int i = 0; i < ScanW; i++) begin
      ridx = cmt_q + ptr_t'(i);
      if (go && i < int'(avail)) begin
        if (!ex_q[ridx[AW-1:0]]) n_ret = n_ret + 1;
        else if (k < n_cmt) begin
          for (int j = 0; j < CmtW; j++)
            if (j == k) begin
              cmt_mem_d[ridx[AW-1:0]] = cmt_data_i[j*CmtDW +: CmtDW];
              tag_bad = tag_bad | (pl_mem_q[ridx[AW-1:0]] != cmt_pl_i[j*PlW +: PlW]);
            end
          k     = k + 1;
          n_ret = n_ret + 1;
        end else go = 1'b0;
      end else go = 1'b0;
    end
    cmt_d      = cmt_q + ptr_t'(n_ret);
    rd_d       = rd_q + ptr_t'(out_valid_o & out_ready_i);
    wr_d       = flush_i ? cmt_d : wr_q + (iss_rdy_q ? ptr_t'(n_iss) : '0);
    iss_rdy_d  = ptr_t'(Depth) - (wr_d - rd_d) >= ptr_t'(IssueW);
    mismatch_d = tag_bad | (k < n_cmt);
    overflow_d = !iss_rdy_q && |iss_valid_i && !flush_i;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q       <= '0;
      cmt_q      <= '0;
      rd_q       <= '0;
      iss_rdy_q  <= 1'b1;
      mismatch_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_q       <= wr_d;
      cmt_q      <= cmt_d;
      rd_q       <= rd_d;
      iss_rdy_q  <= iss_rdy_d;
      mismatch_q <= mismatch_d;
      overflow_q <= overflow_d;
    end
  end
  always_ff @(posedge clk_i) begin
    iss_mem_q <= iss_mem_d;
    cmt_mem_q <= cmt_mem_d;
    pl_mem_q  <= pl_mem_d;
    ex_q      <= ex_d;
  end
  assign iss_rdy_o      = iss_rdy_q;
  assign mismatch_o     = mismatch_q;
  assign overflow_o     = overflow_q;
  assign occupancy_o    = wr_q - rd_q;
  assign out_valid_o    = rd_q != cmt_q;
  assign out_iss_data_o = iss_mem_q[rd_q[AW-1:0]];
  assign out_is_ex_o    = ex_q[rd_q[AW-1:0]];
  assign out_cmt_data_o = out_is_ex_o ? cmt_mem_q[rd_q[AW-1:0]] : '0;
endmodule
